// File: rtl/seg_display_scan.sv
// seg_display_scan: snapshots a counter value into a shadow register and scans
// it as hex onto a multiplexed, common-anode, active-low 7-segment display.
// One digit is driven per SCAN_DIV clock slot. Digit 0 comes first after reset.
// DATA_BITS must be a multiple of 4 in the range 4..32, and SCAN_DIV must be >= 1.

module seg_display_scan #(
    parameter int DATA_BITS = 32,
    parameter int SCAN_DIV  = 100000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_BITS-1:0]   data,
    input  logic                   load,
    input  logic                   blank_lz,
    input  logic [DATA_BITS/4-1:0] dp_mask,
    output logic [DATA_BITS/4-1:0] an,
    output logic [6:0]             seg,
    output logic                   dp,
    output logic                   frame_done
);

    localparam int DIGITS = DATA_BITS / 4;
    localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [DATA_BITS-1:0] shadow;
    logic [DIV_W-1:0]     div;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     idx_next;
    logic                 tick;
    logic [3:0]           nib;
    logic                 dp_bit;
    logic                 zf_sel;
    logic                 blank;
    logic [DIGITS-1:0]    zero_from;
    logic [6:0]           seg_hex;
    logic [DIGITS-1:0]    an_next;
    logic [6:0]           seg_next;
    logic                 dp_next;

    assign tick     = (div == DIV_LAST);
    assign idx_next = (idx == IDX_LAST) ? '0 : idx + 1'b1;

    // Slot divider: free-running 0..SCAN_DIV-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    div <= '0;
        else if (tick) div <= '0;
        else           div <= div + 1'b1;
    end

    // Shadow snapshot. A load in a tick cycle is only seen from the next tick,
    // so a digit never changes inside its slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    shadow <= '0;
        else if (load) shadow <= data;
    end

    // Scan index register. Reset to the last digit so the first tick lands on digit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    idx <= IDX_LAST;
        else if (tick) idx <= idx_next;
    end

    // zero_from[i] is set when every nibble from i up to the top is zero.
    always_comb begin
        zero_from = '0;
        zero_from[DIGITS-1] = (shadow[DATA_BITS-1 -: 4] == 4'h0);
        for (int i = DIGITS - 2; i >= 0; i--)
            zero_from[i] = zero_from[i+1] && (shadow[4*i +: 4] == 4'h0);
    end

    // Select the nibble, the dp bit and the leading-zero status of the digit that comes next.
    always_comb begin
        nib    = 4'h0;
        dp_bit = 1'b0;
        zf_sel = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_next == IDX_W'(i)) begin
                nib    = shadow[4*i +: 4];
                dp_bit = dp_mask[i];
                zf_sel = zero_from[i];
            end
        end
        blank = blank_lz && (idx_next != '0) && zf_sel;
    end

    // Hex to active-low segments {g,f,e,d,c,b,a}.
    always_comb begin
        seg_hex = 7'h7F;
        case (nib)
            4'h0: seg_hex = 7'h40;
            4'h1: seg_hex = 7'h79;
            4'h2: seg_hex = 7'h24;
            4'h3: seg_hex = 7'h30;
            4'h4: seg_hex = 7'h19;
            4'h5: seg_hex = 7'h12;
            4'h6: seg_hex = 7'h02;
            4'h7: seg_hex = 7'h78;
            4'h8: seg_hex = 7'h00;
            4'h9: seg_hex = 7'h10;
            4'hA: seg_hex = 7'h08;
            4'hB: seg_hex = 7'h03;
            4'hC: seg_hex = 7'h46;
            4'hD: seg_hex = 7'h21;
            4'hE: seg_hex = 7'h06;
            4'hF: seg_hex = 7'h0E;
            default: seg_hex = 7'h7F;
        endcase
    end

    // Build the drive for the next digit. A blanked digit turns fully dark, including dp.
    always_comb begin
        an_next  = '1;
        seg_next = 7'h7F;
        dp_next  = 1'b1;
        if (!blank) begin
            for (int i = 0; i < DIGITS; i++)
                an_next[i] = (idx_next != IDX_W'(i));
            seg_next = seg_hex;
            dp_next  = ~dp_bit;
        end
    end

    // Output registers update only on a tick. frame_done marks the first cycle of digit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an         <= '1;
            seg        <= 7'h7F;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= tick && (idx_next == '0);
            if (tick) begin
                an  <= an_next;
                seg <= seg_next;
                dp  <= dp_next;
            end
        end
    end

endmodule

// File: doc/seg_display_scan.md
Name: seg_display_scan

Overview:
- Downstream consumer of the counter block: snapshots a counter value (e.g. the cycle or instruction count) and shows it in hex on a multiplexed, common-anode, active-low 7-segment display.
- Scans one digit per refresh period.
- Snapshot is taken only on request, so the displayed value never tears while the counter runs.

Parameters:
- DATA_BITS, 32, width of value to display; must be a multiple of 4, range 4..32; DIGITS = DATA_BITS/4.
- SCAN_DIV, 100000, clk cycles per digit slot; must be >= 1.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous reset, active low.
- data  input  DATA_BITS  value to display, normally the counter's out.
- load  input  1  when 1 at a rising edge, data is copied into the shadow register.
- blank_lz  input  1  when 1, leading zero digits are blanked.
- dp_mask  input  DIGITS  bit i = 1 lights the decimal point of digit i.
- an  output  DIGITS  digit enables, active low, one-hot-low when lit.
- seg  output  7  segments {g,f,e,d,c,b,a}, active low.
- dp  output  1  decimal point, active low.
- frame_done  output  1  one-cycle pulse when digit 0 becomes active.

Behaviour:
- Reset (async, rst_n=0):
  - shadow=0, div=0, idx=DIGITS-1.
  - an=all 1s, seg=7'h7F, dp=1, frame_done=0.
  - Reset mid-scan forces these values immediately, independent of clk.
- Divider:
  - div counts 0..SCAN_DIV-1 and wraps to 0.
  - tick = (div==SCAN_DIV-1).
  - SCAN_DIV=1 gives a tick every cycle.
- Scan on each tick edge:
  - idx <= (idx==DIGITS-1) ? 0 : idx+1.
  - Output registers load the decode of nibble shadow[4*idx_next+3 : 4*idx_next].
  - Outputs therefore change exactly one cycle after the tick cycle, i.e. SCAN_DIV cycles after reset release for the first digit (digit 0).
  - Outputs hold between ticks.
- Digit drive:
  - an[idx_next]=0, all other an bits = 1.
  - seg = hex decode of the nibble.
  - dp = ~dp_mask[idx_next], sampled at the tick.
- Hex decode (seg hex):
  - 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78
  - 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E
- Leading-zero blanking:
  - Applies only if blank_lz=1 at the tick.
  - Digit i (i>0) is blanked when nibbles DIGITS-1 down to i of shadow are all zero.
  - Blanked digit: an=all 1s, seg=7'h7F, dp=1, regardless of dp_mask.
  - Digit 0 is never blanked, so a value of 0 shows a single "0".
- Shadow register:
  - load=1 at an edge: shadow<=data.
  - load held high: shadow tracks data every cycle.
  - load coincident with a tick: that tick decodes the OLD shadow; the new value appears from the next tick.
  - A digit never changes within its slot.
- frame_done:
  - Registered, =1 for exactly the one cycle in which outputs first show digit 0 (after each tick with idx DIGITS-1 -> 0); otherwise 0.
  - Also fires on the first tick after reset.
- Inputs are synchronous to clk; no internal synchronisers.

Test Plan:
- Reset behaviour:
  - Stimulus: DATA_BITS=16, SCAN_DIV=4, rst_n low.
  - Required: an=4'hF, seg=7'h7F, dp=1.
  - After release, outputs unchanged for 3 cycles.
  - Cycle 4: an=4'hE, frame_done=1 for one cycle.
- Full hex scan:
  - Stimulus: load data=16'hA5C3 (blank_lz=0, dp_mask=0), then observe slots.
  - Required: digit sequence an=E/D/B/7 with seg=30, 46, 12, 08 in turn, then repeats.
  - frame_done pulses every 16 cycles.
- Leading-zero blanking:
  - Stimulus: data=16'h0030, blank_lz=1.
  - Required: digits 3 and 2 have an=4'hF, seg=7F; digit 1 seg=30; digit 0 seg=40.
  - Repeat with data=0: only digit 0 is lit, showing seg=40.
- Load/tick collision:
  - Stimulus: shadow=16'h1111, pulse load with 16'h2222 exactly in a tick cycle.
  - Required: that slot shows seg=79; the next slot shows seg=24.
- Decimal point:
  - Stimulus: dp_mask=4'b0100, data=16'h1234, blank_lz=0.
  - Required: dp=0 only while an=4'hB.
  - Repeat with data=16'h0004, blank_lz=1: digit 2 is blanked and dp stays 1.
- Asynchronous reset mid-slot:
  - Stimulus: assert rst_n=0 between clock edges during digit 2.
  - Required: an=4'hF immediately.
  - After release: shadow=0; the first lit digit is digit 0 showing seg=40.
